ft2232h_led_controller: RTL and testbench
=========================================

FT2232H_LED_CONTROLLER -- requirements
Module: ft2232h_led_controller

Interface
REQ-001 Parameter DATA_W, default 8, width of the FIFO data bus and LED bus.
REQ-002 Parameter LED_RESET_VAL, default 8'h00, value loaded into led_r at reset.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  FT2232H CLKOUT (60 MHz); all state SHALL change on its rising edge only.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 rxf_i  input  1  FT245-sync RXF#, active low; low means the FIFO holds at least one byte.
REQ-007 oe_i  input  1  FT245-sync OE#, active low; driven externally, the data bus is valid only while low.
REQ-008 data_i  input  DATA_W  FIFO read data, sampled on clk_i rising edge.
REQ-009 rd_o  output  1  RD#, active low, registered read strobe to the FIFO.
REQ-010 led_r  output  DATA_W  registered copy of the last byte read.

Function
REQ-011 The FSM SHALL have three states: IDLE, OE_WAIT and READ.
REQ-012 IDLE: rd_o=1; on an edge with rxf_i=0, go to OE_WAIT.
REQ-013 OE_WAIT: rd_o=1; on an edge with rxf_i=0 and oe_i=0, go to READ and drive rd_o=0 from the next cycle; on an edge with rxf_i=1, return to IDLE.
REQ-014 READ: rd_o=0; on each edge with rxf_i=0, oe_i=0 and rd_o=0, load data_i into led_r, one byte per cycle, with no gaps.
REQ-015 READ: on an edge with rxf_i=1 or oe_i=1, take no capture on that edge, drive rd_o=1 from the next cycle and go to IDLE.
REQ-016 Capture-to-LED latency SHALL be one clock; led_r SHALL hold its value between captures.
REQ-017 If rxf_i deasserts on the same edge a byte would be captured, that byte SHALL NOT be captured.
REQ-018 From rxf_i falling to the first capture SHALL take at least 2 edges: detect, then OE qualification.
REQ-019 rd_o SHALL never be low while oe_i is high for more than one cycle.
REQ-020 X or Z on data_i outside a capture edge SHALL NOT affect led_r.

Reset
REQ-021 When rst_i=1 at an edge: state=IDLE, rd_o=1, led_r=LED_RESET_VAL; reset SHALL override every other input.
REQ-022 A reset during READ SHALL deassert rd_o on the next cycle and discard any capture on that edge.
REQ-023 When rst_i is held low throughout, the block SHALL operate normally from the first edge in IDLE, using its register initial values.

Configuration
REQ-024 Macro FT_LED_BYTECOUNT_EN.
- Defined: adds output byte_cnt_o[15:0], which increments on each capture, wraps 16'hFFFF to 0 and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Structure
REQ-025 Package ft2232h_pkg SHALL hold the FSM state typedef (IDLE, OE_WAIT, READ), the default DATA_W and the active-low level constants ASSERT_N=0 and DEASSERT_N=1.
REQ-026 The block SHALL be a single module with no sub-modules; the FSM and the capture register are small enough to stay inline.

Verification
REQ-027 Reset: rst_i=1 for 2 cycles, rxf_i=0 -> rd_o=1 and led_r=8'h00 throughout; after release, the first capture occurs no earlier than edge 2.
REQ-028 Burst: rxf_i low, oe_i following rxf_i registered, FIFO supplies 8'h01..8'h05 -> rd_o low for 5 captures, and led_r steps 01,02,03,04,05 one clock after each.
REQ-029 Empty mid-burst: rxf_i rises after byte 8'h03 -> rd_o=1 on the next cycle, led_r stays 8'h03 and the FSM returns to IDLE.
REQ-030 OE held high with rxf_i=0 for 10 cycles -> rd_o stays 1, FSM stays in OE_WAIT, led_r unchanged.
REQ-031 Reset asserted while in READ with data_i=8'hAA -> led_r=8'h00 and rd_o=1 after that edge; 8'hAA is not captured.
REQ-032 With FT_LED_BYTECOUNT_EN defined: stream 300 bytes -> byte_cnt_o=16'd300; preload 16'hFFFF then capture 1 byte -> byte_cnt_o=0.

Source files
------------

// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H FT245-sync LED controller.
package ft2232h_pkg;

   // Default width of the FIFO data bus and LED bus
   localparam int unsigned DEFAULT_DATA_W = 8;

   // Active-low strobe levels used on RXF#, OE# and RD#
   localparam logic ASSERT_N   = 1'b0;
   localparam logic DEASSERT_N = 1'b1;

   // Read FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OE_WAIT = 2'd1,
      READ    = 2'd2
   } state_t;

endpackage : ft2232h_pkg

// File: rtl/ft2232h_led_controller.sv
// FT2232H FT245-sync FIFO reader that mirrors the last byte read onto an LED bus.
// Optional feature: define FT_LED_BYTECOUNT_EN to add a 16-bit wrapping capture counter
// on output byte_cnt_o.
module ft2232h_led_controller
   import ft2232h_pkg::*;
#(
   parameter int unsigned       DATA_W        = DEFAULT_DATA_W,
   parameter logic [DATA_W-1:0] LED_RESET_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rxf_i,
   input  logic              oe_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              rd_o,
   output logic [DATA_W-1:0] led_r
`ifdef FT_LED_BYTECOUNT_EN
   ,
   output logic [15:0]       byte_cnt_o
`endif
);

   // Power-up values let the block run correctly even if reset is never asserted
   state_t            state_q = IDLE;
   state_t            state_d;
   logic              rd_q    = DEASSERT_N;
   logic [DATA_W-1:0] led_q   = LED_RESET_VAL;
   logic              rd_d;
   logic              capture_c;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: detect data, qualify OE#, then stream until either strobe drops
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (rxf_i == ASSERT_N) begin
               state_d = OE_WAIT;
            end
         end
         OE_WAIT: begin
            if (rxf_i == DEASSERT_N) begin
               state_d = IDLE;
            end else if (oe_i == ASSERT_N) begin
               state_d = READ;
            end
         end
         READ: begin
            if ((rxf_i == DEASSERT_N) || (oe_i == DEASSERT_N)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: RD# follows the state being entered; capture only on a fully qualified edge
   always_comb begin
      rd_d      = DEASSERT_N;
      capture_c = 1'b0;
      if (state_d == READ) begin
         rd_d = ASSERT_N;
      end
      if ((state_q == READ) && (rxf_i == ASSERT_N) && (oe_i == ASSERT_N) &&
          (rd_q == ASSERT_N)) begin
         capture_c = 1'b1;
      end
   end

   // Registered RD# strobe and LED capture; data_i is ignored outside capture edges
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= DEASSERT_N;
         led_q <= LED_RESET_VAL;
      end else begin
         rd_q <= rd_d;
         if (capture_c) begin
            led_q <= data_i;
         end
      end
   end

   assign rd_o  = rd_q;
   assign led_r = led_q;

`ifdef FT_LED_BYTECOUNT_EN
   logic [15:0] byte_cnt_q = '0;

   // Count captured bytes, wrapping naturally at 16 bits
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         byte_cnt_q <= '0;
      end else if (capture_c) begin
         byte_cnt_q <= byte_cnt_q + 16'(1);
      end
   end

   assign byte_cnt_o = byte_cnt_q;
`endif

endmodule : ft2232h_led_controller

// File: tb/tb_ft2232h_led_controller.sv
// Scoreboard bench for ft2232h_led_controller: the driver queues expected LED values,
// a monitor pops and compares them whenever led_r changes.
module tb_ft2232h_led_controller;
   import ft2232h_pkg::*;

   logic       clk;
   logic       rst;
   logic       rxf;
   logic       oe;
   logic [7:0] data;
   logic       rd;
   logic [7:0] led;
`ifdef FT_LED_BYTECOUNT_EN
   logic [15:0] byte_cnt;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] prev_led = 8'h00;
   logic [7:0] nb;
   logic [7:0] last_byte;

   ft2232h_led_controller #(
      .DATA_W       (8),
      .LED_RESET_VAL(8'h00)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .rxf_i (rxf),
      .oe_i  (oe),
      .data_i(data),
      .rd_o  (rd),
      .led_r (led)
`ifdef FT_LED_BYTECOUNT_EN
      ,
      .byte_cnt_o(byte_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Monitor: every change on led_r must match the next queued expectation
   always @(negedge clk) begin
      if (led !== prev_led) begin
         if (exp_q.size() == 0) begin
            chk("led_unexpected", 32'(led), 32'(prev_led));
         end else begin
            chk("led_scoreboard", 32'(led), 32'(exp_q.pop_front()));
         end
         prev_led = led;
      end
   end

   // From IDLE: detect, qualify OE#, stream n bytes from nb, then stop via RXF# or OE#
   task automatic burst(input int n, input bit stop_oe, input logic [7:0] stop_data);
      rxf = 1'b0; oe = 1'b1; data = 8'hC3;
      tick();
      chk("detect_rd_high", 32'(rd), 32'(1));
      oe = 1'b0;
      tick();
      chk("enter_read_rd_low", 32'(rd), 32'(0));
      for (int i = 0; i < n; i++) begin
         data = nb;
         exp_q.push_back(nb);
         last_byte = nb;
         nb = nb + 8'd1;
         tick();
         chk("burst_rd_low", 32'(rd), 32'(0));
      end
      if (stop_oe) oe = 1'b1;
      else         rxf = 1'b1;
      data = stop_data;
      tick();
      chk("stop_rd_high", 32'(rd), 32'(1));
      chk("stop_led_hold", 32'(led), 32'(last_byte));
      rxf = 1'b1; oe = 1'b1;
      tick();
      chk("stop_state_idle", 32'(dut.state_q), 32'(IDLE));
   endtask

   // Hard bound on run time
   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; rxf = 1'b0; oe = 1'b0; data = 8'h55;
      // Reset held two cycles with RXF#/OE# asserted
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("reset_rd", 32'(rd), 32'(1));
         chk("reset_led", 32'(led), 32'(0));
      end
`ifdef FT_LED_BYTECOUNT_EN
      chk("reset_cnt", 32'(byte_cnt), 32'(0));
`endif
      rst = 1'b0;
      tick();
      chk("post_reset_edge1_rd", 32'(rd), 32'(1));
      chk("post_reset_edge1_state", 32'(dut.state_q), 32'(OE_WAIT));
      tick();
      chk("post_reset_edge2_rd", 32'(rd), 32'(0));
      chk("post_reset_edge2_led", 32'(led), 32'(0));
      rxf = 1'b1;
      tick();
      chk("post_reset_abort_rd", 32'(rd), 32'(1));
      chk("post_reset_abort_led", 32'(led), 32'(0));
      oe = 1'b1;
      tick();

      // Five-byte burst 01..05, FIFO empties with 06 on the bus
      nb = 8'h01;
      burst(5, 1'b0, 8'h06);

      // Empty mid-burst after 03; EE on the stop edge is not captured
      nb = 8'h01;
      burst(3, 1'b0, 8'hEE);

      // OE# drop ends a burst of 40,41; 42 is not captured
      nb = 8'h40;
      burst(2, 1'b1, 8'h42);

      // OE# held high with data while bus is X: stay in OE_WAIT, LED unchanged
      rxf = 1'b0; oe = 1'b1; data = 'x;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("oe_high_rd", 32'(rd), 32'(1));
         chk("oe_high_state", 32'(dut.state_q), 32'(OE_WAIT));
         chk("oe_high_led", 32'(led), 32'(8'h41));
      end
      rxf = 1'b1;
      tick();
      chk("oe_high_exit_state", 32'(dut.state_q), 32'(IDLE));

      // Reset while in READ with AA on the bus
      rxf = 1'b0; oe = 1'b1; data = 8'h00;
      tick();
      oe = 1'b0;
      tick();
      chk("rst_read_enter_rd", 32'(rd), 32'(0));
      data = 8'h11;
      exp_q.push_back(8'h11);
      tick();
      data = 8'hAA; rst = 1'b1;
      exp_q.push_back(8'h00);
      tick();
      chk("rst_in_read_rd", 32'(rd), 32'(1));
      chk("rst_in_read_led", 32'(led), 32'(0));
      rst = 1'b0; rxf = 1'b1; oe = 1'b1;
      tick();
      chk("rst_in_read_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_in_read_led_hold", 32'(led), 32'(0));

`ifdef FT_LED_BYTECOUNT_EN
      // Counter: 300 captures, then up to 16'hFFFF, then wrap to zero
      nb = 8'h01;
      burst(300, 1'b0, 8'h00);
      chk("cnt_300", 32'(byte_cnt), 32'(300));
      burst(65535 - 300, 1'b0, 8'h00);
      chk("cnt_ffff", 32'(byte_cnt), 32'(16'hFFFF));
      burst(1, 1'b0, 8'h00);
      chk("cnt_wrap", 32'(byte_cnt), 32'(0));
`endif

      tick();
      tick();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_ft2232h_led_controller
